wall_ctrl_multi: RTL and testbench
==================================

# wall_ctrl_multi

Parametrised wall controller for the game datapath. It manages N_WALLS independent walls, each with its own READY/MOVE/STOP state and x position. On every frame tick it runs one erase/update/draw pass over all walls, in index order. All drawing goes through a single shared request/done handshake to the VGA draw engine, replacing the single-wall controller and its ad-hoc DRAW/DEL/UPDATE sequencing.

## Interface
- N_WALLS, 4: number of walls (1..8)
- X_W, 8: x-position width
- X_START, 159: spawn/reset x of every wall
- STEP, 1: pixels moved per tick (1..X_START)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state on the rising clk edge where it is high
- tick  in  1  one-cycle frame strobe
- go  in  N_WALLS  per-wall start request (level)
- touched  in  N_WALLS  per-wall collision (level)
- restart  in  N_WALLS  per-wall return STOP→READY (level)
- draw_req  out  1  draw engine request
- draw_erase  out  1  1 = erase (background colour), 0 = draw wall
- draw_idx  out  3  wall index of request
- draw_x  out  X_W  x of request
- draw_done  in  1  engine completion, one-cycle pulse
- wall_state  out  4*N_WALLS  per-wall state code, wall i in bits [4i+3:4i]
- wall_x  out  X_W*N_WALLS  per-wall current x
- wrap  out  N_WALLS  one-cycle pulse when wall i wraps
- busy  out  1  sequencer not in S_IDLE

## Operation
- Per-wall FSM, codes: W_READY=4'b0101, W_MOVE=4'b0110, W_STOP=4'b0111.
  - READY→MOVE when go[i] = 1 and touched[i] = 0.
  - MOVE→STOP when touched[i] = 1. This is evaluated every cycle, including mid-scan.
  - STOP→READY when restart[i] = 1. On this transition x[i] returns to X_START and painted[i] clears.
  - touched has priority over go and restart in the same cycle.
- Sequencer states: S_IDLE, S_SEL, S_ERASE, S_UPD, S_DRAW, S_NEXT.
  - S_IDLE: on a tick, or on a pending tick, set idx=0 → S_SEL.
  - S_SEL, wall in MOVE: → S_ERASE.
  - S_SEL, wall in READY with painted=0: → S_DRAW. This paints the wall at X_START and sets painted.
  - S_SEL, otherwise: → S_NEXT.
  - S_ERASE: request erase at the old x; on draw_done → S_UPD.
  - S_UPD: if x < STEP then x ← X_START and pulse wrap[i]; else x ← x − STEP. → S_DRAW.
  - S_DRAW: request draw at the current x; on draw_done → S_NEXT.
  - S_NEXT: idx+1. If idx == N_WALLS−1 → S_IDLE, else → S_SEL.
- A wall that moves to STOP during its own ERASE/UPD/DRAW finishes that pass. It is skipped from the next pass onward and stays drawn at its final x.
- A tick arriving while busy sets a 1-deep pending flag. Further ticks while the flag is set are dropped. The pending flag is consumed on the next entry to S_IDLE.
- Arithmetic is unsigned X_W-bit and never underflows, because of the x < STEP check.

## Timing
- Reset values:
  - draw_req=0, draw_erase=0, draw_idx=0, draw_x=0.
  - All walls W_READY, x=X_START, painted=0.
  - wrap=0, busy=0, sequencer S_IDLE, pending=0.
- draw_req rises the cycle after entering S_ERASE or S_DRAW.
- While draw_req is high, draw_erase, draw_idx and draw_x are stable.
- draw_req falls in the cycle after draw_done is sampled high.
- draw_done is ignored when draw_req=0.
- Latency from tick to the first draw_req is 3 cycles (S_IDLE→S_SEL→S_ERASE→req). Engine latency D is the number of cycles draw_req is high before draw_done.
- A moving wall costs 2D+5 cycles per pass. A skipped wall costs 2 cycles.
- wrap[i] is high for exactly the one cycle after S_UPD.
- Reset mid-handshake drops draw_req on the next edge. A late draw_done is ignored.

## Test plan
- Reset, go=4'b0001, tick, D=2:
  - First tick: READY paint of walls 0–3 at x=159 (draw_erase=0), wall 0 →MOVE.
  - Second tick: erase idx0 x=159, then draw idx0 x=158.
- STEP=1, wall 0 moving, 159 ticks to x=0:
  - The next tick erases x=0 and draws x=159.
  - wrap[0] pulses once.
- Wall 1 moving, touched[1] asserted during S_DRAW for wall 1:
  - The pass completes; wall_state[7:4]=0111.
  - The next tick issues no requests with idx=1.
- Wall in STOP, restart pulse:
  - State 0101, wall_x=159.
  - The next tick repaints it once (draw_erase=0, x=159).
- Three ticks during a long pass (D=20):
  - Exactly one extra pass runs immediately after busy falls.
- Reset asserted while draw_req=1:
  - draw_req=0 next cycle, all walls READY at 159.
  - A draw_done pulse afterwards causes no state change.

Source files
------------

// File: rtl/wall_ctrl_multi.sv
// Multi-wall controller for the game datapath.
//
// Holds N_WALLS walls. Each wall has a READY/MOVE/STOP state and an x position.
// Every frame tick runs one erase/update/draw pass over all walls in index
// order. Every pixel operation goes through a single shared req/done handshake
// to the VGA draw engine.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tick                one-cycle frame strobe
//   go/touched/restart  per-wall level controls (touched has priority)
//   draw_req/erase/idx/x  draw engine request; fields are held while req is high
//   draw_done           engine completion pulse; ignored while draw_req is low
//   wall_state          4-bit state code per wall, wall i in [4i+3:4i]
//   wall_x              X_W-bit x per wall, wall i in [X_W*i +: X_W]
//   wrap                one-cycle pulse when wall i wraps back to X_START
//   busy                sequencer is running a pass
module wall_ctrl_multi #(
  parameter int unsigned N_WALLS = 4,
  parameter int unsigned X_W     = 8,
  parameter int unsigned X_START = 159,
  parameter int unsigned STEP    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [N_WALLS-1:0]       go,
  input  logic [N_WALLS-1:0]       touched,
  input  logic [N_WALLS-1:0]       restart,
  output logic                     draw_req,
  output logic                     draw_erase,
  output logic [2:0]               draw_idx,
  output logic [X_W-1:0]           draw_x,
  input  logic                     draw_done,
  output logic [4*N_WALLS-1:0]     wall_state,
  output logic [X_W*N_WALLS-1:0]   wall_x,
  output logic [N_WALLS-1:0]       wrap,
  output logic                     busy
);

  localparam int unsigned IdxW   = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
  localparam logic [2:0]  LastIdx = 3'(N_WALLS - 1);
  localparam logic [X_W-1:0] XStart = X_W'(X_START);
  localparam logic [X_W-1:0] Step   = X_W'(STEP);

  localparam logic [3:0] WReady = 4'b0101;
  localparam logic [3:0] WMove  = 4'b0110;
  localparam logic [3:0] WStop  = 4'b0111;

  typedef enum logic [2:0] {SIdle, SSel, SErase, SUpd, SDraw, SNext} seq_e;

  seq_e                seq_q, seq_d;
  logic [2:0]          idx_q, idx_d;
  logic                pend_q, pend_d;
  logic                req_q, req_d;
  logic                erase_q, erase_d;
  logic [2:0]          didx_q, didx_d;
  logic [X_W-1:0]      dx_q, dx_d;
  logic [N_WALLS-1:0]  wrap_q, wrap_d;
  logic [N_WALLS-1:0]  painted_q, painted_d;
  logic [3:0]          wst_q [N_WALLS];
  logic [3:0]          wst_d [N_WALLS];
  logic [X_W-1:0]      x_q [N_WALLS];
  logic [X_W-1:0]      x_d [N_WALLS];
  logic [IdxW-1:0]     sel;

  // idx_q never exceeds N_WALLS-1, so the narrow select is lossless.
  assign sel = idx_q[IdxW-1:0];

  always_comb begin
    seq_d     = seq_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    req_d     = req_q;
    erase_d   = erase_q;
    didx_d    = didx_q;
    dx_d      = dx_q;
    wrap_d    = '0;
    painted_d = painted_q;
    wst_d     = wst_q;
    x_d       = x_q;

    // 1-deep tick memory; extra ticks while it is set are dropped.
    if (seq_q != SIdle && tick) pend_d = 1'b1;

    case (seq_q)
      SIdle: begin
        if (tick || pend_q) begin
          idx_d  = 3'd0;
          pend_d = 1'b0;
          seq_d  = SSel;
        end
      end
      SSel: begin
        if (wst_q[sel] == WMove) begin
          seq_d = SErase;
        end else if (wst_q[sel] == WReady && !painted_q[sel]) begin
          painted_d[sel] = 1'b1;
          seq_d          = SDraw;
        end else begin
          seq_d = SNext;
        end
      end
      SErase: begin
        // req is low only on the entry cycle; it drops together with leaving.
        if (!req_q) begin
          req_d   = 1'b1;
          erase_d = 1'b1;
          didx_d  = idx_q;
          dx_d    = x_q[sel];
        end else if (draw_done) begin
          req_d = 1'b0;
          seq_d = SUpd;
        end
      end
      SUpd: begin
        if (x_q[sel] < Step) begin
          x_d[sel]    = XStart;
          wrap_d[sel] = 1'b1;
        end else begin
          x_d[sel] = x_q[sel] - Step;
        end
        seq_d = SDraw;
      end
      SDraw: begin
        if (!req_q) begin
          req_d   = 1'b1;
          erase_d = 1'b0;
          didx_d  = idx_q;
          dx_d    = x_q[sel];
        end else if (draw_done) begin
          req_d = 1'b0;
          seq_d = SNext;
        end
      end
      SNext: begin
        if (idx_q == LastIdx) begin
          seq_d = SIdle;
        end else begin
          idx_d = idx_q + 3'd1;
          seq_d = SSel;
        end
      end
      default: seq_d = SIdle;
    endcase

    // Per-wall state runs every cycle, independent of the scan. Placed after
    // the sequencer so a restart wins over a same-cycle position update.
    for (int unsigned i = 0; i < N_WALLS; i++) begin
      case (wst_q[i])
        WReady: if (go[i] && !touched[i]) wst_d[i] = WMove;
        WMove:  if (touched[i]) wst_d[i] = WStop;
        WStop: begin
          if (restart[i] && !touched[i]) begin
            wst_d[i]     = WReady;
            x_d[i]       = XStart;
            painted_d[i] = 1'b0;
          end
        end
        default: wst_d[i] = WReady;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q     <= SIdle;
      idx_q     <= 3'd0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      erase_q   <= 1'b0;
      didx_q    <= 3'd0;
      dx_q      <= '0;
      wrap_q    <= '0;
      painted_q <= '0;
      for (int unsigned i = 0; i < N_WALLS; i++) begin
        wst_q[i] <= WReady;
        x_q[i]   <= XStart;
      end
    end else begin
      seq_q     <= seq_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      erase_q   <= erase_d;
      didx_q    <= didx_d;
      dx_q      <= dx_d;
      wrap_q    <= wrap_d;
      painted_q <= painted_d;
      for (int unsigned i = 0; i < N_WALLS; i++) begin
        wst_q[i] <= wst_d[i];
        x_q[i]   <= x_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_WALLS; g++) begin : gen_pack
    assign wall_state[4*g +: 4] = wst_q[g];
    assign wall_x[X_W*g +: X_W] = x_q[g];
  end

  assign draw_req   = req_q;
  assign draw_erase = erase_q;
  assign draw_idx   = didx_q;
  assign draw_x     = dx_q;
  assign wrap       = wrap_q;
  assign busy       = (seq_q != SIdle);

endmodule

// File: tb/tb_wall_ctrl_multi.sv
// Self-checking bench for wall_ctrl_multi (default parameters).
// A behavioural engine answers requests after eng_d cycles. Each pass's expected
// requests are queued when its tick is driven and popped as the DUT issues them.
module tb_wall_ctrl_multi;

  localparam int NW = 4;
  localparam int XW = 8;
  localparam logic [3:0] W_READY = 4'b0101;
  localparam logic [3:0] W_MOVE  = 4'b0110;
  localparam logic [3:0] W_STOP  = 4'b0111;

  logic clk = 1'b0;
  logic reset, tick, draw_done;
  logic [NW-1:0] go, touched, restart;
  logic draw_req, draw_erase, busy;
  logic [2:0] draw_idx;
  logic [XW-1:0] draw_x;
  logic [4*NW-1:0] wall_state;
  logic [XW*NW-1:0] wall_x;
  logic [NW-1:0] wrap;

  wall_ctrl_multi #(.N_WALLS(NW), .X_W(XW), .X_START(159), .STEP(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .go(go), .touched(touched), .restart(restart),
    .draw_req(draw_req), .draw_erase(draw_erase), .draw_idx(draw_idx), .draw_x(draw_x),
    .draw_done(draw_done), .wall_state(wall_state), .wall_x(wall_x), .wrap(wrap),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic erase; logic [2:0] idx; logic [7:0] x;} req_t;
  req_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Engine and monitor state
  int   eng_d = 2;
  logic manual = 1'b0;
  logic man_done = 1'b0;
  logic eng_done = 1'b0;
  int   cnt = 0;
  logic prev_req = 1'b0;
  logic prev_busy = 1'b0;
  req_t cur;
  int   idx1_reqs = 0;
  int   busy_rises = 0;
  int   wrap_cnt [NW];

  // Reference model
  logic [3:0] m_st [NW];
  logic [7:0] m_x [NW];
  logic       m_painted [NW];
  int         m_wraps [NW];

  assign draw_done = manual ? man_done : eng_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_st[i] = W_READY;
      m_x[i] = 8'd159;
      m_painted[i] = 1'b0;
    end
  endtask

  task automatic push(input logic e, input int i, input logic [7:0] x);
    req_t r;
    r.erase = e;
    r.idx = 3'(i);
    r.x = x;
    exp_q.push_back(r);
  endtask

  // Expected requests of one pass, updating the model as the pass would.
  task automatic push_pass();
    for (int i = 0; i < NW; i++) begin
      if (m_st[i] == W_MOVE) begin
        push(1'b1, i, m_x[i]);
        if (m_x[i] < 8'd1) begin
          m_x[i] = 8'd159;
          m_wraps[i]++;
        end else begin
          m_x[i] = m_x[i] - 8'd1;
        end
        push(1'b0, i, m_x[i]);
      end else if (m_st[i] == W_READY && !m_painted[i]) begin
        push(1'b0, i, 8'd159);
        m_painted[i] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NW; i++) wrap_cnt[i] += int'(wrap[i]);
    if (busy && !prev_busy) busy_rises++;
    prev_busy = busy;
    if (draw_req) begin
      if (!prev_req) begin
        cur = {draw_erase, draw_idx, draw_x};
        if (draw_idx == 3'd1) idx1_reqs++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_req: got erase=%0d idx=%0d x=%0d, required none",
                   draw_erase, draw_idx, draw_x);
        end else begin
          check("req_fields", {draw_erase, draw_idx, draw_x}, exp_q.pop_front());
        end
        cnt = 1;
      end else begin
        check("req_stable", {draw_erase, draw_idx, draw_x}, cur);
        cnt++;
      end
      eng_done = (cnt == eng_d);
    end else begin
      cnt = 0;
      eng_done = 1'b0;
    end
    prev_req = draw_req;
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy still 1, required 0 within 3000 cycles");
    end
  endtask

  // Called right after a negedge.
  task automatic run_tick();
    tick = 1'b1;
    push_pass();
    @(negedge clk);
    tick = 1'b0;
    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_go(input logic [NW-1:0] m);
    go = m;
    for (int i = 0; i < NW; i++)
      if (m[i] && m_st[i] == W_READY) m_st[i] = W_MOVE;
    @(negedge clk);
    go = '0;
  endtask

  typedef struct {
    logic [3:0]  go;
    int          ticks;
    int          d;
    logic [15:0] st;
    logic [31:0] x;
  } row_t;
  row_t rows [6];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rows[0] = '{4'b0000, 1,   2, 16'h5555, 32'h9F9F9F9F};  // paint all READY walls
    rows[1] = '{4'b0001, 1,   2, 16'h5556, 32'h9F9F9F9E};  // wall 0 starts
    rows[2] = '{4'b0000, 10,  1, 16'h5556, 32'h9F9F9F94};
    rows[3] = '{4'b0100, 3,   3, 16'h5656, 32'h9F9C9F91};  // wall 2 joins
    rows[4] = '{4'b0000, 145, 1, 16'h5656, 32'h9F0B9F00};  // wall 0 reaches x=0
    rows[5] = '{4'b0000, 1,   1, 16'h5656, 32'h9F0A9F9F};  // wall 0 wraps

    for (int i = 0; i < NW; i++) begin
      m_wraps[i] = 0;
      wrap_cnt[i] = 0;
    end
    model_reset();
    reset = 1'b1; tick = 1'b0; go = '0; touched = '0; restart = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_draw_req", draw_req, 0);
    check("rst_draw_erase", draw_erase, 0);
    check("rst_draw_idx", draw_idx, 0);
    check("rst_draw_x", draw_x, 0);
    check("rst_wall_state", wall_state, 16'h5555);
    check("rst_wall_x", wall_x, 32'h9F9F9F9F);
    check("rst_wrap", wrap, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      eng_d = rows[r].d;
      if (rows[r].go != 4'b0000) pulse_go(rows[r].go);
      for (int t = 0; t < rows[r].ticks; t++) run_tick();
      check($sformatf("row%0d_state", r), wall_state, rows[r].st);
      check($sformatf("row%0d_x", r), wall_x, rows[r].x);
    end
    check("wrap0_once", 64'(wrap_cnt[0]), 64'd1);
    for (int i = 0; i < NW; i++)
      check($sformatf("wrap_cnt%0d", i), 64'(wrap_cnt[i]), 64'(m_wraps[i]));

    // Wall 1 touched while its draw request is outstanding
    eng_d = 3;
    pulse_go(4'b0010);
    tick = 1'b1;
    push_pass();
    @(negedge clk);
    tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (draw_req && draw_idx == 3'd1 && !draw_erase) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("touch_draw_seen", seen, 1'b1);
    touched = 4'b0010;
    m_st[1] = W_STOP;
    @(negedge clk);
    touched = '0;
    wait_idle();
    check("touch_queue", 64'(exp_q.size()), 64'd0);
    check("touch_state1", wall_state[7:4], W_STOP);
    check("touch_x1", wall_x[15:8], 8'd158);
    idx1_reqs = 0;
    run_tick();
    check("stop_no_idx1", 64'(idx1_reqs), 64'd0);

    // Restart a stopped wall: back at spawn, repainted once
    restart = 4'b0010;
    m_st[1] = W_READY;
    m_x[1] = 8'd159;
    m_painted[1] = 1'b0;
    @(negedge clk);
    restart = '0;
    check("restart_state1", wall_state[7:4], W_READY);
    check("restart_x1", wall_x[15:8], 8'd159);
    idx1_reqs = 0;
    run_tick();
    check("restart_repaint", 64'(idx1_reqs), 64'd1);

    // Ticks during a long pass collapse to a single extra pass
    eng_d = 20;
    busy_rises = 0;
    tick = 1'b1;
    push_pass();
    push_pass();
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("pend_first_done", seen, 1'b1);
    @(negedge clk);
    check("pend_restart", busy, 1'b1);
    wait_idle();
    repeat (40) @(negedge clk);
    check("pend_quiet", busy, 1'b0);
    check("pend_passes", 64'(busy_rises), 64'd2);
    check("pend_queue", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a handshake
    eng_d = 2;
    tick = 1'b1;
    push_pass();
    @(negedge clk);
    tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (draw_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_req_seen", seen, 1'b1);
    manual = 1'b1;
    man_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    check("mid_rst_req", draw_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", wall_state, 16'h5555);
    check("mid_rst_x", wall_x, 32'h9F9F9F9F);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check("late_done_req", draw_req, 0);
    check("late_done_busy", busy, 0);
    check("late_done_state", wall_state, 16'h5555);
    manual = 1'b0;
    run_tick();
    check("post_rst_state", wall_state, 16'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
